imem_loader_ctrl: RTL
=====================

IMEM_LOADER_CTRL -- requirements
Module: imem_loader_ctrl

Interface
REQ-001 Parameter DEPTH, default 101: instruction memory depth in 32-bit words.
REQ-002 Parameter AW, default 7: word-address width, SHALL satisfy 2^AW >= DEPTH.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ld_start  input  1  single-cycle request to begin a program load.
REQ-006 ld_len  input  AW  number of words to load; sampled with ld_start.
REQ-007 ld_valid  input  1  host word valid.
REQ-008 ld_data  input  32  host instruction word.
REQ-009 ld_ready  output  1  controller accepts a word this cycle.
REQ-010 mem_we  output  1  instruction memory write strobe.
REQ-011 mem_waddr  output  AW  instruction memory write word address.
REQ-012 mem_wdata  output  32  instruction memory write data.
REQ-013 pc  input  32  core program counter (byte address).
REQ-014 fetch_addr  output  AW  instruction memory read word address.
REQ-015 core_run  output  1  core enable; 0 holds the core stalled.
REQ-016 fetch_fault  output  1  pc out of range or misaligned while running.
REQ-017 ld_done  output  1  one-cycle pulse when a load completes.
REQ-018 ld_err  output  1  sticky error flag for a rejected load request.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, DONE and RUN; reset state is IDLE.
REQ-020 IDLE: ld_start with 1 <= ld_len <= DEPTH -> LOAD, word counter cleared, length latched.
REQ-021 IDLE: ld_start with ld_len == 0 or ld_len > DEPTH -> ld_err set, stay IDLE.
REQ-022 ld_ready SHALL be 1 only in LOAD.
REQ-023 Handshake: word accepted when ld_valid && ld_ready; ld_data unused otherwise.
REQ-024 An accepted word SHALL produce mem_we=1 on the next cycle, with mem_waddr = counter value at acceptance and mem_wdata = accepted data (registered write, 1-cycle latency).
REQ-025 mem_we SHALL be 0 in every cycle not following an accepted word.
REQ-026 Counter increments by 1 per accepted word; it never wraps, since LOAD exits at count == latched length.
REQ-027 Acceptance of the final word (count == length-1) -> DONE; ld_ready is 0 from the next cycle.
REQ-028 DONE lasts exactly one cycle, coincides with the final mem_we, asserts ld_done, then -> RUN.
REQ-029 RUN: core_run = 1, fetch_addr = pc[AW+1:2].
REQ-030 Outside RUN: core_run = 0 and fetch_addr = 0.
REQ-031 fetch_fault (combinational) = RUN && (pc[1:0] != 0 || pc[31:2] >= DEPTH).
REQ-032 RUN: a valid ld_start -> LOAD (reload); core_run drops the next cycle. An invalid ld_start sets ld_err and stays in RUN.
REQ-033 ld_start in LOAD or DONE SHALL be ignored, with no error.
REQ-034 ld_valid with ld_valid de-asserted mid-load: the FSM stalls in LOAD indefinitely with no timeout.
REQ-035 ld_err SHALL be cleared only by a valid ld_start or by reset.

Reset
REQ-036 rst_n low SHALL asynchronously force: IDLE, counter=0, length=0, mem_we=0, mem_waddr=0, mem_wdata=0, ld_done=0, ld_err=0, ld_ready=0, core_run=0.
REQ-037 Reset asserted mid-LOAD SHALL abandon the load with no further mem_we; the partially written memory is not restored.

Structure
REQ-038 A shared package SHALL hold the FSM state enumeration (2-bit) and the DEPTH/AW defaults.
REQ-039 The design SHALL be a single module with no sub-modules; the memory instance lives at top level.

Verification
REQ-040 Reset, then ld_start with ld_len=3 and words 0xA0,0xA1,0xA2 back-to-back -> mem_we at addresses 0,1,2 one cycle after each accept; ld_done 1 cycle; core_run=1 the next cycle.
REQ-041 ld_len=4 with ld_valid gaps of 2 cycles -> exactly 4 writes at consecutive addresses; no duplicate mem_we.
REQ-042 ld_start with ld_len=0, then with ld_len=102 -> ld_err=1, state stays IDLE, mem_we never asserted.
REQ-043 RUN with pc=0x190 -> fetch_addr=100, fetch_fault=0; pc=0x194 -> fetch_fault=1; pc=0x2 -> fetch_fault=1.
REQ-044 rst_n low after 2 of 5 words -> all outputs at reset values asynchronously; no further writes.
REQ-045 RUN, then ld_start with ld_len=1 -> core_run=0 the next cycle; one write to address 0; core returns to RUN after DONE.

Source files
------------

// File: rtl/imem_loader_ctrl_pkg.sv
// imem_loader_ctrl_pkg: shared state type, default geometry and request checks
// for the instruction-memory program loader.
package imem_loader_ctrl_pkg;

   // Default instruction memory geometry (32-bit words).
   localparam int unsigned IMEM_DEPTH_DEFAULT = 101;
   localparam int unsigned IMEM_AW_DEFAULT    = 7;

   // Loader / core-control states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2,
      ST_RUN  = 2'd3
   } ld_state_e;

   // A load request is acceptable when it asks for 1..depth words.
   function automatic logic len_in_range(input int unsigned len,
                                         input int unsigned depth);
      return (len != 0) && (len <= depth);
   endfunction

   // A fetch is faulty when pc is not word aligned or addresses past the memory.
   function automatic logic pc_is_bad(input logic [31:0] pc,
                                      input int unsigned depth);
      return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: accepts a program from a host over a valid/ready stream,
// writes it word by word into the instruction memory, then releases the core
// and maps its byte PC onto the memory read port. A new valid request while
// running stalls the core and reloads the memory.
module imem_loader_ctrl
   import imem_loader_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = IMEM_DEPTH_DEFAULT,
   parameter int unsigned AW    = IMEM_AW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   // host load interface
   input  logic          ld_start,
   input  logic [AW-1:0] ld_len,
   input  logic          ld_valid,
   input  logic [31:0]   ld_data,
   output logic          ld_ready,
   // instruction memory write port
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [31:0]   mem_wdata,
   // core interface
   input  logic [31:0]   pc,
   output logic [AW-1:0] fetch_addr,
   output logic          core_run,
   output logic          fetch_fault,
   // status
   output logic          ld_done,
   output logic          ld_err
);

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   ld_state_e     r_state;
   logic [AW-1:0] r_cnt;
   logic [AW-1:0] r_len;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_waddr;
   logic [31:0]   r_mem_wdata;
   logic          r_ld_done;
   logic          r_ld_err;
   logic          r_ld_ready;
   logic          r_core_run;

   // ------------------------------------------------------------------
   // Decoded conditions
   // ------------------------------------------------------------------
   logic          w_len_ok;
   logic          w_accept;
   logic          w_last;
   logic          w_running;
   logic [AW-1:0] w_fetch_addr;
   logic          w_fetch_fault;

   // Request qualification and handshake decode for the current cycle.
   always_comb begin
      w_len_ok  = len_in_range(32'(ld_len), DEPTH);
      w_accept  = ld_valid && r_ld_ready;
      w_last    = (r_cnt == (r_len - AW'(1)));
      w_running = (r_state == ST_RUN);
   end

   // Core-side address mapping; the fault flag is purely combinational on pc.
   always_comb begin
      w_fetch_addr  = '0;
      w_fetch_fault = 1'b0;
      if (w_running) begin
         w_fetch_addr  = pc[AW+1:2];
         w_fetch_fault = pc_is_bad(pc, DEPTH);
      end
   end

   // Loader FSM; every output except the fetch path is registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_len       <= '0;
         r_mem_we    <= 1'b0;
         r_mem_waddr <= '0;
         r_mem_wdata <= '0;
         r_ld_done   <= 1'b0;
         r_ld_err    <= 1'b0;
         r_ld_ready  <= 1'b0;
         r_core_run  <= 1'b0;
      end else begin
         // write strobe and done are single-cycle unless re-armed below
         r_mem_we  <= 1'b0;
         r_ld_done <= 1'b0;

         case (r_state)
            // IDLE and RUN react to load requests identically; only
            // core_run differs, and a valid request always clears it.
            ST_IDLE, ST_RUN: begin
               if (ld_start) begin
                  if (w_len_ok) begin
                     r_state    <= ST_LOAD;
                     r_cnt      <= '0;
                     r_len      <= ld_len;
                     r_ld_err   <= 1'b0;
                     r_ld_ready <= 1'b1;
                     r_core_run <= 1'b0;
                  end else begin
                     r_ld_err   <= 1'b1;
                  end
               end
            end

            // Accept words until the latched length is reached; ld_start
            // is ignored while a load is in flight.
            ST_LOAD: begin
               if (w_accept) begin
                  r_mem_we    <= 1'b1;
                  r_mem_waddr <= r_cnt;
                  r_mem_wdata <= ld_data;
                  r_cnt       <= r_cnt + AW'(1);
                  if (w_last) begin
                     r_state    <= ST_DONE;
                     r_ld_ready <= 1'b0;
                     r_ld_done  <= 1'b1;
                  end
               end
            end

            // One cycle carrying the final write and the done pulse.
            ST_DONE: begin
               r_state    <= ST_RUN;
               r_core_run <= 1'b1;
            end

            default: begin
               r_state    <= ST_IDLE;
               r_ld_ready <= 1'b0;
               r_core_run <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output wiring
   // ------------------------------------------------------------------
   assign ld_ready    = r_ld_ready;
   assign mem_we      = r_mem_we;
   assign mem_waddr   = r_mem_waddr;
   assign mem_wdata   = r_mem_wdata;
   assign ld_done     = r_ld_done;
   assign ld_err      = r_ld_err;
   assign core_run    = r_core_run;
   assign fetch_addr  = w_fetch_addr;
   assign fetch_fault = w_fetch_fault;

endmodule
